// File: rtl/lerp_pkg.sv
// lerp_pkg: operand bundle and FSM state encoding shared by lerp2_sched and its bench.
package lerp_pkg;
  localparam int LERP_W = 32;
  typedef struct packed {
    logic signed [LERP_W-1:0] p0, p1, p2, p3, x, y, X, Y;
  } lerp_req_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} lerp_sched_state_e;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin select of the first valid at or after ptr, searching cyclically.
module rr_pick #(
  parameter int N = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   valid,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx,
  output logic           any
);
  int j;
  always_comb begin
    idx = '0;
    j = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (valid[j[IDW-1:0]]) idx = j[IDW-1:0];
    end
  end
  assign any = |valid;
  assign gnt = any ? N'(1) << idx : '0;
endmodule

// File: rtl/lerp2_sched.sv
// lerp2_sched: round-robin sharing of one lerp2 among N_REQ requesters.
// LERP2_SCHED_BYPASS_EN: zero-extent requests (X==0 or Y==0) are answered with p0 without using lerp2.
module lerp2_sched
  import lerp_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = LERP_W,
  localparam int IDW = $clog2(N_REQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  lerp_req_t [N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]      resp_valid,
  input  logic [N_REQ-1:0]      resp_ready,
  output logic [WIDTH-1:0]      resp_val,
  output logic [IDW-1:0]        resp_id,
  output logic                  resp_bypass,
  output lerp_req_t             lerp_op,
  output logic                  lerp_start,
  input  logic                  lerp_done,
  input  logic [WIDTH-1:0]      lerp_val,
  output logic                  busy
);
  lerp_sched_state_e state;
  logic [IDW-1:0] rr_ptr, pick_idx;
  logic [N_REQ-1:0] pick_gnt;
  logic pick_any, byp;
  rr_pick #(.N(N_REQ)) u_pick (
    .valid(req_valid),
    .ptr(rr_ptr),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );
  // reset gates the grant so req_ready reads zero while held in reset
  assign req_ready = (state == IDLE && reset) ? pick_gnt : '0;
`ifdef LERP2_SCHED_BYPASS_EN
  assign byp = req_data[pick_idx].X == '0 || req_data[pick_idx].Y == '0;
  always_ff @(posedge clock or negedge reset)
    if (!reset) resp_bypass <= 1'b0;
    else if (state == IDLE && pick_any) resp_bypass <= byp;
    else if (state == RESP && resp_ready[resp_id]) resp_bypass <= 1'b0;
`else
  assign byp = 1'b0;
  assign resp_bypass = 1'b0;
`endif
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      resp_id <= '0;
      lerp_op <= '0;
      resp_val <= '0;
      resp_valid <= '0;
      lerp_start <= 1'b0;
      busy <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (pick_any) begin
          resp_id <= pick_idx;
          lerp_op <= req_data[pick_idx];
          busy <= 1'b1;
          if (byp) begin
            resp_val <= req_data[pick_idx].p0;
            resp_valid <= pick_gnt;
            state <= RESP;
          end else begin
            lerp_start <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          lerp_start <= 1'b0;
          state <= WAIT;
        end
        WAIT: if (lerp_done) begin
          resp_val <= lerp_val;
          resp_valid <= N_REQ'(1) << resp_id;
          state <= RESP;
        end
        RESP: if (resp_ready[resp_id]) begin
          resp_valid <= '0;
          busy <= 1'b0;
          rr_ptr <= resp_id == IDW'(N_REQ - 1) ? '0 : resp_id + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/lerp2_sched.md
# lerp2_sched

Round-robin scheduler that shares one `lerp2` bilinear interpolator among `N_REQ` requesters, for example per-column voxel shading units. It accepts one request at a time over a valid/ready handshake and drives the interpolator's operand, `start` and `done` pins. It then returns the result to the granting requester over a per-requester response handshake. It sits between the shading front ends and a single `lerp2` instance.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `WIDTH`, 32: operand/result width; must match the `lerp2` instance.
- `IDW`, `$clog2(N_REQ)`: requester-index width (localparam).
- `clock` in 1: single clock; all state on its rising edge.
- `reset` in 1: asynchronous, active-low.
- `req_valid` in N_REQ: per-requester request valid.
- `req_ready` out N_REQ: one-hot accept strobe.
- `req_data` in N_REQ × `lerp_req_t`: {p0,p1,p2,p3,x,y,X,Y}, each WIDTH signed.
- `resp_valid` out N_REQ: one-hot result valid.
- `resp_ready` in N_REQ: per-requester result accept.
- `resp_val` out WIDTH: result, shared by all requesters.
- `resp_id` out IDW: index of the requester being answered.
- `resp_bypass` out 1: result was produced by the zero-extent bypass.
- `lerp_op` out `lerp_req_t`: operands to `lerp2`.
- `lerp_start` out 1: one-cycle start pulse.
- `lerp_done` in 1: `lerp2` done.
- `lerp_val` in WIDTH: `lerp2` result.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - The grant goes to the first `req_valid` at or after `rr_ptr`, searching cyclically.
  - `req_ready[g]` is high combinationally in the same cycle.
  - The transfer completes that cycle: latch `req_data[g]` into `op_q` and latch `g`.
  - Next state is ISSUE (or RESP under bypass).
- **ISSUE:** `lerp_start`=1 for exactly this cycle; next state is WAIT.
- **WAIT:** on `lerp_done`=1, capture `lerp_val` into `res_q` and go to RESP. `lerp_done` is ignored in every other state.
- **RESP:**
  - `resp_valid[g]`=1, `resp_val`=`res_q`, `resp_id`=g.
  - `resp_valid`, `resp_val` and `resp_id` are held until `resp_ready[g]`.
  - Then `rr_ptr` ← (g+1) mod N_REQ and the FSM returns to IDLE.
  - `resp_ready` bits for other requesters are ignored.
- `lerp_op` is driven from `op_q` continuously. It is stable from the ISSUE cycle through the end of WAIT.
- A requester must keep `req_valid` and `req_data` stable until accepted. Withdrawing `req_valid` early is legal; the scheduler never grants a requester whose `req_valid` is low.
- Only one request is in flight. `req_ready` is all-zero outside IDLE.

## Timing
- **Reset values:**
  - State IDLE, `rr_ptr`=0.
  - `req_ready`, `resp_valid`, `lerp_start`, `busy`, `resp_bypass` all 0.
  - `resp_val`, `resp_id`, `lerp_op` all 0.
- **Latency:** accept at cycle T, `lerp_start` at T+1. If `lerp_done` arrives at T+1+D, `resp_valid` is asserted at T+2+D.
- **Back-to-back:** a response accepted at cycle R allows the next accept at R+1 (the IDLE cycle). Minimum issue interval is D+3 cycles.
- **`lerp_done` in the WAIT entry cycle:** accepted. A `lerp_done` coinciding with `lerp_start` (ISSUE) is ignored.
- **Reset mid-operation:**
  - Everything returns to reset values at once and the in-flight result is discarded.
  - The integrator drives the `lerp2` reset from the same reset event.
- **Fairness:** with all N_REQ requesters valid continuously, grants rotate 0,1,…,N_REQ-1,0…

## Configuration
- `LERP2_SCHED_BYPASS_EN` defined:
  - At accept, if X==0 or Y==0, skip ISSUE/WAIT.
  - `res_q` ← p0, `resp_bypass`=1, next state RESP.
  - `resp_valid` is asserted at T+1.
- Undefined:
  - All requests go to `lerp2` unmodified. Zero-extent results are whatever the divider returns.
  - `resp_bypass` is tied to 0.

## Structure
- Package `lerp_pkg`:
  - `lerp_req_t` packed struct (8 × WIDTH, with WIDTH as a package parameter matching the `lerp2` default).
  - FSM state enum `lerp_sched_state_e`.
- Sub-module `rr_pick`: combinational round-robin one-hot select from (`req_valid`, `rr_ptr`) returning a one-hot grant and an index.

## Test plan
- **Single request:**
  - Stimulus: requester 2 only, bench `lerp2` model answers 0x0006_0000 after 5 cycles.
  - Response: `lerp_start` at T+1, `resp_valid`=4'b0100 and `resp_val`=0x0006_0000 at T+7, `resp_id`=2.
- **All four valid continuously, `resp_ready` always 1:** grant order 0,1,2,3,0. Each accept is exactly D+3 cycles apart.
- **Response backpressure:**
  - Stimulus: `resp_ready` held low 10 cycles after `resp_valid`.
  - Response: `resp_valid`, `resp_val` and `resp_id` are stable, and `req_ready` stays 0 throughout.
- **Reset mid-operation:**
  - Stimulus: `reset` low during WAIT.
  - Response: all outputs 0 asynchronously. A later `lerp_done` is ignored. The next grant starts from requester 0.
- **Zero extent, `LERP2_SCHED_BYPASS_EN` defined:**
  - Stimulus: X=0, p0=0x0003_0000.
  - Response: no `lerp_start`, `resp_val`=0x0003_0000 and `resp_bypass`=1 at T+1.
- **Zero extent, macro undefined:** `lerp_start` is issued for the same request and `resp_bypass`=0.
